// File: rtl/dz_pkg.sv
// Shared types and constants for the DZ receive silo.
// Holds: the silo entry layout, RBUF bit positions, DEPTH/ALARM defaults,
// the scanner state encoding and the entry-to-RBUF packing helper.
package dz_pkg;

    localparam int unsigned DZ_DEPTH_DEF = 64;
    localparam int unsigned DZ_ALARM_DEF = 16;
    localparam int unsigned DZ_LINES     = 8;
    localparam int unsigned DZ_RBUF_W    = 16;

    // RBUF bit positions
    localparam int unsigned RB_VALID    = 15;
    localparam int unsigned RB_OVRN     = 14;
    localparam int unsigned RB_FRME     = 13;
    localparam int unsigned RB_PARE     = 12;
    localparam int unsigned RB_ZERO     = 11;
    localparam int unsigned RB_LINE_LSB = 8;
    localparam int unsigned RB_CHAR_LSB = 0;

    // One silo entry as stored in the FIFO
    typedef struct packed {
        logic       ovrn;
        logic       frme;
        logic       pare;
        logic [2:0] lnum;
        logic [7:0] chr;
    } dz_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CLEAR = 2'd2
    } dz_state_e;

    // Lay a valid entry out in RBUF format
    function automatic logic [DZ_RBUF_W-1:0] dz_rbuf(input dz_entry_t e);
        logic [DZ_RBUF_W-1:0] r;
        r                    = '0;
        r[RB_VALID]          = 1'b1;
        r[RB_OVRN]           = e.ovrn;
        r[RB_FRME]           = e.frme;
        r[RB_PARE]           = e.pare;
        r[RB_ZERO]           = 1'b0;
        r[RB_LINE_LSB +: 3]  = e.lnum;
        r[RB_CHAR_LSB +: 8]  = e.chr;
        return r;
    endfunction

endpackage

// File: rtl/dz_rx_silo_if.sv
// Bus between the DZ receive silo and its environment (UARTs + CSR side).
// master: UART/CSR side driving clr/mse/saen/rx*/rbufREAD.
// slave : the silo, driving rxclr/rbufDATA/rdone/sa.
interface dz_rx_silo_if;
    import dz_pkg::*;

    logic                  clr;
    logic                  mse;
    logic                  saen;
    logic [DZ_LINES-1:0]   rxfull;
    logic [DZ_LINES*8-1:0] rxdata;
    logic [DZ_LINES-1:0]   rxpare;
    logic [DZ_LINES-1:0]   rxfrme;
    logic [DZ_LINES-1:0]   rxclr;
    logic                  rbufREAD;
    logic [DZ_RBUF_W-1:0]  rbufDATA;
    logic                  rdone;
    logic                  sa;

    modport master (
        output clr, mse, saen, rxfull, rxdata, rxpare, rxfrme, rbufREAD,
        input  rxclr, rbufDATA, rdone, sa
    );

    modport slave (
        input  clr, mse, saen, rxfull, rxdata, rxpare, rxfrme, rbufREAD,
        output rxclr, rbufDATA, rdone, sa
    );

endinterface

// File: rtl/dz_silo_fifo.sv
// Synchronous FIFO holding silo entries.
// Ports: clk, rst (async active-low), clr_i (sync clear), wr_en_i/wr_data_i,
// rd_en_i, rd_data_o (head entry), full_o, empty_o, count_o.
// Writes into a full FIFO and reads from an empty FIFO are dropped.
module dz_silo_fifo
    import dz_pkg::*;
#(
    parameter int unsigned DEPTH = DZ_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  dz_entry_t                  wr_data_i,
    input  logic                       rd_en_i,
    output dz_entry_t                  rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    dz_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push, pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem[rd_ptr_q];
    assign push      = wr_en_i && !full_o && !clr_i;
    assign pop       = rd_en_i && !empty_o && !clr_i;

    // Pointers and occupancy, all modulo DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/dz_rx_silo.sv
// DZ receive silo: scans eight UART receivers, pushes characters into a
// FIFO silo, tracks overrun, and raises a silo alarm.
// Ports: clk, rst (async active-low), bus (dz_rx_silo_if.slave).
// Optional: define DZ_SILO_ALARM_EN to build the silo alarm counter/flag;
// otherwise sa is tied low and saen is ignored.
module dz_rx_silo
    import dz_pkg::*;
#(
    parameter int unsigned DEPTH = DZ_DEPTH_DEF,
    parameter int unsigned ALARM = DZ_ALARM_DEF
) (
    input  logic         clk,
    input  logic         rst,
    dz_rx_silo_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    dz_state_e     state_q, state_d;
    logic [2:0]    line_q, line_d;
    logic [7:0]    rxclr_q, rxclr_d;
    logic          ovrn_q, ovrn_d;
    logic          wr_en, rd_en;
    dz_entry_t     wr_entry, head;
    logic          full, empty;
    logic [CW-1:0] count;

    assign rd_en = bus.rbufREAD && !bus.clr;

    // Scanner next-state, write request and overrun tracking
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        rxclr_d  = '0;
        ovrn_d   = ovrn_q;
        wr_en    = 1'b0;
        wr_entry = '{ovrn: ovrn_q,
                     frme: bus.rxfrme[line_q],
                     pare: bus.rxpare[line_q],
                     lnum: line_q,
                     chr:  bus.rxdata[{line_q, 3'b000} +: 8]};
        case (state_q)
            ST_IDLE: begin
                if (bus.mse) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (!bus.mse) begin
                    state_d = ST_IDLE;
                end else begin
                    line_d = line_q + 3'd1;
                    if (bus.rxfull[line_q]) begin
                        rxclr_d[line_q] = 1'b1;
                        state_d         = ST_CLEAR;
                        if (full) begin
                            ovrn_d = 1'b1;
                        end else begin
                            wr_en  = 1'b1;
                            ovrn_d = 1'b0;
                        end
                    end
                end
            end
            // Dead cycle so the UART flag drops before the next sample
            ST_CLEAR: begin
                state_d = bus.mse ? ST_SCAN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.clr) begin
            state_d = ST_IDLE;
            line_d  = '0;
            rxclr_d = '0;
            ovrn_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    // Scanner state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            rxclr_q <= '0;
            ovrn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            rxclr_q <= rxclr_d;
            ovrn_q  <= ovrn_d;
        end
    end

    dz_silo_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (bus.clr),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_entry),
        .rd_en_i   (rd_en),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count)
    );

    assign bus.rxclr    = rxclr_q;
    assign bus.rdone    = (count != '0);
    assign bus.rbufDATA = empty ? '0 : dz_rbuf(head);

`ifdef DZ_SILO_ALARM_EN
    localparam int unsigned ALW = $clog2(ALARM + 1);

    logic [ALW-1:0] acnt_q, acnt_d;
    logic           sa_q, sa_d;

    // Writes since last read, saturating at ALARM
    always_comb begin
        acnt_d = acnt_q;
        sa_d   = sa_q;
        if (bus.clr || !bus.saen || bus.rbufREAD) begin
            acnt_d = '0;
            sa_d   = 1'b0;
        end else begin
            if (wr_en && (acnt_q != ALW'(ALARM))) acnt_d = acnt_q + ALW'(1);
            if (acnt_d == ALW'(ALARM)) sa_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acnt_q <= '0;
            sa_q   <= 1'b0;
        end else begin
            acnt_q <= acnt_d;
            sa_q   <= sa_d;
        end
    end

    assign bus.sa = sa_q;
`else
    localparam int unsigned unused_alarm = ALARM;
    logic unused_saen;
    assign unused_saen = bus.saen;
    assign bus.sa      = 1'b0;
`endif

endmodule

// File: doc/dz_rx_silo.md
DZ_RX_SILO -- requirements
Module: dz_rx_silo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, silo entry count (power of two, 16..256).
REQ-002 SHALL have parameter ALARM, default 16, characters-since-last-read count that raises silo alarm.
REQ-003 SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  in  1  synchronous device clear (CSR CLR / bus init), active-high.
REQ-006 SHALL have port mse  in  1  master scan enable; scanner runs only while high.
REQ-007 SHALL have port saen  in  1  silo alarm enable.
REQ-008 SHALL have port rxfull  in  8  per-line receiver-full flags from the eight UARTs.
REQ-009 SHALL have port rxdata  in  64  per-line received characters, line n at bits 8n+7:8n.
REQ-010 SHALL have port rxpare  in  8  per-line parity error.
REQ-011 SHALL have port rxfrme  in  8  per-line framing error.
REQ-012 SHALL have port rxclr  out  8  per-line one-cycle receiver flag clear pulse.
REQ-013 SHALL have port rbufREAD  in  1  one-cycle RBUF read strobe; pops head entry.
REQ-014 SHALL have port rbufDATA  out  16  head entry: 15 VALID, 14 OVRN, 13 FRME, 12 PARE, 11 zero, 10:8 line, 7:0 char.
REQ-015 SHALL have port rdone  out  1  silo not empty.
REQ-016 SHALL have port sa  out  1  silo alarm flag.

Function
REQ-017 Scanner SHALL be an FSM with states IDLE, SCAN, CLEAR; IDLE while mse low, SCAN when mse high.
REQ-018 In SCAN a 3-bit line counter SHALL advance one line per clock, wrapping 7->0.
REQ-019 When rxfull[line] is high in SCAN, the entry {pare,frme,line,char} SHALL be written the same edge, rxclr[line] pulsed high exactly one cycle, and FSM enters CLEAR.
REQ-020 CLEAR SHALL last exactly one cycle (no sampling) so the UART flag deasserts, then return to SCAN at line+1.
REQ-021 mse falling SHALL force IDLE at next edge without losing the counter value; any pending rxclr pulse still completes.
REQ-022 Written entry SHALL appear on rbufDATA/rdone the cycle after the write edge.
REQ-023 rbufDATA SHALL be all zero when silo empty; VALID=1 otherwise.
REQ-024 rbufREAD on non-empty silo SHALL pop head at the edge; rbufREAD while empty SHALL be ignored.
REQ-025 Simultaneous write and pop SHALL both occur with count unchanged; write into an empty silo with concurrent read SHALL not pop the new entry.
REQ-026 A character arriving with silo full SHALL be discarded, its rxclr still pulsed, and an overrun latch set.
REQ-027 The overrun latch SHALL be copied into OVRN of the next written entry and then cleared.
REQ-028 An alarm counter SHALL count writes since last rbufREAD, saturating at ALARM; reaching ALARM with saen high SHALL set sa.
REQ-029 rbufREAD SHALL clear alarm counter and sa; saen low SHALL hold sa low and the counter at zero.
REQ-030 Pointer and count arithmetic SHALL be modulo DEPTH with count width log2(DEPTH)+1.

Reset
REQ-031 rst low SHALL asynchronously force: FSM IDLE, line 0, silo empty, overrun latch 0, alarm counter 0, rxclr 0, rbufDATA 0, rdone 0, sa 0.
REQ-032 clr SHALL produce the same state synchronously, overriding simultaneous writes and reads, including mid-CLEAR.

Configuration
REQ-033 Macro DZ_SILO_ALARM_EN defined SHALL compile in REQ-028/029 alarm logic; undefined SHALL tie sa to 0, remove the alarm counter, ignore saen.

Structure
REQ-034 Package dz_pkg SHALL hold the silo entry struct typedef, the rbufDATA bit-position constants, and the DEPTH/ALARM defaults.
REQ-035 Storage SHALL be one sub-module dz_silo_fifo (synchronous FIFO, write/read/full/empty/count); scanner, overrun and alarm logic stay in dz_rx_silo.

Verification
REQ-036 mse=1, rxfull[3]=1, rxdata line3=0x41 -> one rxclr[3] pulse, rbufDATA=0x8341, rdone=1.
REQ-037 rxfull[0], rxfull[5] simultaneously high -> entries line 0 then line 5 in order, each rxclr one cycle.
REQ-038 Fill 64 entries, send 2 more, read one, send 0x55 on line 2 -> only 0x55 entry has OVRN=1 (0xC255), prior two lost.
REQ-039 saen=1, write 16 chars without read -> sa rises after 16th write; one rbufREAD -> sa=0.
REQ-040 rst low while in CLEAR with 5 entries -> all outputs zero immediately; after release mse=1 scan restarts at line 0.
